// File: rtl/pmem_burst_adapter.sv
// Line-to-burst adapter: splits one 256-bit line transfer into 64-bit pmem beats and reassembles reads.
// Optional statistics counters are enabled by defining PMEM_ADAPTER_STATS_EN.
module pmem_burst_adapter #(
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [ADDR_W-1:0] line_address,
   input  logic [LINE_W-1:0] line_wdata,
   output logic [LINE_W-1:0] line_rdata,
   output logic              line_resp,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [ADDR_W-1:0] bmem_address,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_resp
`ifdef PMEM_ADAPTER_STATS_EN
   ,
   output logic [31:0]       stat_reads,
   output logic [31:0]       stat_writes,
   output logic [31:0]       stat_beats
`endif
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } state_t;

   state_t                        state;
   state_t                        next_state;
   logic [CNT_W-1:0]              cnt;
   logic [BEATS-1:0][BEAT_W-1:0]  wline;
   logic [BEATS-1:0][BEAT_W-1:0]  rline;
   logic                          beat_done;
   logic                          last_beat;
   logic                          addr_unused;

   // Offset bits inside a line never reach the narrow port.
   assign addr_unused = ^line_address[OFF_W-1:0];

   assign beat_done  = bmem_resp && ((state == RD_BURST) || (state == WR_BURST));
   assign last_beat  = beat_done && (cnt == LAST);
   assign line_rdata = rline;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (line_read) begin
               next_state = RD_BURST;
            end else if (line_write) begin
               next_state = WR_BURST;
            end
         end
         RD_BURST: begin
            if (last_beat) begin
               next_state = DONE;
            end
         end
         WR_BURST: begin
            if (last_beat) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      line_resp  = 1'b0;
      bmem_wdata = '0;
      case (state)
         RD_BURST: bmem_read = 1'b1;
         WR_BURST: begin
            bmem_write = 1'b1;
            bmem_wdata = wline[cnt];
         end
         DONE:     line_resp = 1'b1;
         default:  ;
      endcase
   end

   // Request capture and beat bookkeeping; the counter parks on the last beat until DONE clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         bmem_address <= '0;
         wline        <= '0;
         rline        <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (line_read) begin
                  bmem_address <= {line_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               end else if (line_write) begin
                  bmem_address <= {line_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  wline        <= line_wdata;
               end
            end
            RD_BURST: begin
               if (bmem_resp) begin
                  rline[cnt] <= bmem_rdata;
                  if (cnt != LAST) begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            WR_BURST: begin
               if (bmem_resp && (cnt != LAST)) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               cnt <= '0;
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

`ifdef PMEM_ADAPTER_STATS_EN
   // Saturating activity counters for completed lines and beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_reads  <= '0;
         stat_writes <= '0;
         stat_beats  <= '0;
      end else begin
         if (last_beat && (state == RD_BURST) && (stat_reads != 32'hFFFF_FFFF)) begin
            stat_reads <= stat_reads + 32'd1;
         end
         if (last_beat && (state == WR_BURST) && (stat_writes != 32'hFFFF_FFFF)) begin
            stat_writes <= stat_writes + 32'd1;
         end
         if (beat_done && (stat_beats != 32'hFFFF_FFFF)) begin
            stat_beats <= stat_beats + 32'd1;
         end
      end
   end
`endif

endmodule
